// File: rtl/uart_hash_rx.sv
// uart_hash_rx: line-oriented hex hash receiver behind a byte UART.
// Collects DIGITS hex characters per line, publishes them as one wide hash on
// end-of-line, rejects malformed lines, and optionally echoes received bytes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no digits collected on the current line (count 0)
// S_COLLECT | one or more digits collected, waiting for more or EOL
// S_FLUSH   | line rejected, discarding bytes until the next EOL
//
// DIGITS must be 2 or more.
module uart_hash_rx #(
   parameter int DIGITS = 32,
   parameter int ECHO   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx_valid,
   input  logic [7:0]                   rx_byte,
   input  logic                         rx_error,
   input  logic                         tx_busy,
   output logic                         tx_transmit,
   output logic [7:0]                   tx_byte,
   output logic [4*DIGITS-1:0]          hash,
   output logic                         hash_valid,
   output logic                         parse_error,
   output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

   localparam int              CW      = $clog2(DIGITS + 1);
   localparam int              SW      = 4 * DIGITS;
   localparam logic [CW-1:0]   FULL    = CW'(DIGITS);
   localparam logic [CW-1:0]   ONE     = CW'(1);
   localparam bit              ECHO_EN = (ECHO != 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_FLUSH   = 2'd2
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [SW-1:0]   sr_q;
   logic [SW-1:0]   hash_q;
   logic            hash_valid_q;
   logic            parse_error_q;

   logic            buf_full_q;
   logic            req_q;
   logic            seen_busy_q;
   logic            tx_transmit_q;
   logic [7:0]      tx_byte_q;

   logic            is_hex_d;
   logic            is_eol_d;
   logic            is_bs_d;
   logic [3:0]      nib_d;

   // Classify the incoming byte and decode its hex value.
   always_comb begin
      is_hex_d = 1'b0;
      is_eol_d = 1'b0;
      is_bs_d  = 1'b0;
      nib_d    = 4'd0;
      if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
         is_hex_d = 1'b1;
         nib_d    = rx_byte[3:0];
      end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                   (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
         is_hex_d = 1'b1;
         nib_d    = rx_byte[3:0] + 4'd9;
      end else if (rx_byte == 8'h0D || rx_byte == 8'h0A) begin
         is_eol_d = 1'b1;
      end else if (rx_byte == 8'h08) begin
         is_bs_d = 1'b1;
      end
   end

   // Line parser: digit shift register, digit count, hash and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         sr_q          <= '0;
         hash_q        <= '0;
         hash_valid_q  <= 1'b0;
         parse_error_q <= 1'b0;
      end else begin
         hash_valid_q  <= 1'b0;
         parse_error_q <= 1'b0;
         if (rx_error) begin
            // a framing error spoils the line; in FLUSH it is already spoiled
            if (state_q != S_FLUSH) begin
               parse_error_q <= 1'b1;
               state_q       <= S_FLUSH;
            end
         end else if (rx_valid) begin
            case (state_q)
               S_IDLE, S_COLLECT: begin
                  if (is_hex_d) begin
                     if (cnt_q < FULL) begin
                        sr_q    <= {sr_q[SW-5:0], nib_d};
                        cnt_q   <= cnt_q + ONE;
                        state_q <= S_COLLECT;
                     end else begin
                        parse_error_q <= 1'b1;
                        state_q       <= S_FLUSH;
                     end
                  end else if (is_eol_d) begin
                     // EOL with nothing collected is a blank line or the LF of CRLF
                     if (state_q == S_COLLECT) begin
                        if (cnt_q == FULL) begin
                           hash_q       <= sr_q;
                           hash_valid_q <= 1'b1;
                        end else begin
                           parse_error_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                     end
                  end else if (is_bs_d) begin
                     // the low 4*count bits always hold the live digits, so
                     // dropping the newest one is a plain right shift
                     if (state_q == S_COLLECT) begin
                        sr_q  <= sr_q >> 4;
                        cnt_q <= cnt_q - ONE;
                        if (cnt_q == ONE) begin
                           state_q <= S_IDLE;
                        end
                     end
                  end else begin
                     parse_error_q <= 1'b1;
                     state_q       <= S_FLUSH;
                  end
               end
               S_FLUSH: begin
                  if (is_eol_d) begin
                     cnt_q   <= '0;
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   // One-entry echo buffer: capture when empty, request once the transmitter
   // is idle, release after the transmitter has gone busy and idle again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full_q    <= 1'b0;
         req_q         <= 1'b0;
         seen_busy_q   <= 1'b0;
         tx_transmit_q <= 1'b0;
         tx_byte_q     <= 8'd0;
      end else begin
         tx_transmit_q <= 1'b0;
         if (!buf_full_q) begin
            if (ECHO_EN && rx_valid && !rx_error) begin
               tx_byte_q  <= rx_byte;
               buf_full_q <= 1'b1;
            end
         end else if (!req_q) begin
            if (!tx_busy) begin
               tx_transmit_q <= 1'b1;
               req_q         <= 1'b1;
            end
         end else if (!seen_busy_q) begin
            if (tx_busy) begin
               seen_busy_q <= 1'b1;
            end
         end else if (!tx_busy) begin
            buf_full_q  <= 1'b0;
            req_q       <= 1'b0;
            seen_busy_q <= 1'b0;
         end
      end
   end

   assign tx_transmit = tx_transmit_q;
   assign tx_byte     = tx_byte_q;
   assign hash        = hash_q;
   assign hash_valid  = hash_valid_q;
   assign parse_error = parse_error_q;
   assign digit_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_hash_rx.sv
// Self-checking bench for uart_hash_rx: expected hash/parse_error events are
// queued as bytes are driven and matched when the DUT pulses.
module tb_uart_hash_rx;

   localparam int        HW = 128;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] BS = 8'h08;
   localparam int        EV_NONE = 0;
   localparam int        EV_PERR = 1;
   localparam int        EV_HASH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            rx_valid;
   logic [7:0]      rx_byte;
   logic            rx_error;
   logic            tx_busy;
   logic            tx_transmit;
   logic [7:0]      tx_byte;
   logic [HW-1:0]   hash;
   logic            hash_valid;
   logic            parse_error;
   logic [5:0]      digit_cnt;

   logic            tx_transmit0;
   logic [7:0]      tx_byte0;
   logic [15:0]     hash0;
   logic            hash_valid0;
   logic            parse_error0;
   logic [2:0]      digit_cnt0;

   int              n_tests = 0;
   int              n_fail  = 0;
   int              exp_kind_q[$];
   logic [HW-1:0]   exp_hash_q[$];
   int              tx_cnt  = 0;
   int              tx0_cnt = 0;
   logic [7:0]      last_tx = 8'd0;
   int              busy_cnt = 0;
   logic            busy_force = 1'b0;
   logic [HW-1:0]   h_prev;
   int              tx_before;

   uart_hash_rx #(.DIGITS(32), .ECHO(1)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .rx_error(rx_error), .tx_busy(tx_busy), .tx_transmit(tx_transmit),
      .tx_byte(tx_byte), .hash(hash), .hash_valid(hash_valid),
      .parse_error(parse_error), .digit_cnt(digit_cnt)
   );

   uart_hash_rx #(.DIGITS(4), .ECHO(0)) dut_noecho (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .rx_error(rx_error), .tx_busy(tx_busy), .tx_transmit(tx_transmit0),
      .tx_byte(tx_byte0), .hash(hash0), .hash_valid(hash_valid0),
      .parse_error(parse_error0), .digit_cnt(digit_cnt0)
   );

   always #5 clk = ~clk;

   // Simple transmitter model: busy for 6 cycles after each request.
   assign tx_busy = busy_force || (busy_cnt != 0);
   always @(posedge clk) begin
      if (tx_transmit) busy_cnt <= 6;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every status pulse.
   always @(negedge clk) begin : mon
      int            k;
      logic [HW-1:0] h;
      if (tx_transmit) begin
         tx_cnt++;
         last_tx = tx_byte;
      end
      if (tx_transmit0) tx0_cnt++;
      if (hash_valid && parse_error) begin
         chk("pulse_exclusive", {hash_valid, parse_error}, 2'b00);
      end else if (hash_valid || parse_error) begin
         if (exp_kind_q.size() == 0) begin
            chk("unexpected_pulse", {hash_valid, parse_error}, 2'b00);
         end else begin
            k = exp_kind_q.pop_front();
            h = exp_hash_q.pop_front();
            chk("event_kind", hash_valid ? EV_HASH : EV_PERR, k);
            if (k == EV_HASH) chk("hash_value", hash, h);
         end
      end
   end

   task automatic drive(input logic [7:0] b, input logic v, input logic e,
                        input int kind, input logic [HW-1:0] eh);
      @(negedge clk);
      rx_valid = v;
      rx_error = e;
      rx_byte  = b;
      if (kind != EV_NONE) begin
         exp_kind_q.push_back(kind);
         exp_hash_q.push_back(eh);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rx_error = 1'b0;
      #1;
      if (kind != EV_NONE) begin
         chk("event_latency", exp_kind_q.size(), 0);
         if (exp_kind_q.size() != 0) begin
            exp_kind_q.delete();
            exp_hash_q.delete();
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int kind, input logic [HW-1:0] eh);
      drive(b, 1'b1, 1'b0, kind, eh);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], EV_NONE, '0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_error = 1'b0; rx_byte = 8'd0;
      idle(3);
      chk("rst_hash", hash, '0);
      chk("rst_hash_valid", hash_valid, 0);
      chk("rst_parse_error", parse_error, 0);
      chk("rst_tx_transmit", tx_transmit, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_digit_cnt", digit_cnt, 0);
      rst = 1'b0;
      idle(2);

      // full valid line, CRLF terminated
      send_str("0113df004fea93a20fb02c1fa5fda95d");
      chk("cnt_full", digit_cnt, 32);
      send_byte(CR, EV_HASH, 128'h0113df004fea93a20fb02c1fa5fda95d);
      send_byte(LF, EV_NONE, '0);
      chk("line1_hash", hash, 128'h0113df004fea93a20fb02c1fa5fda95d);
      chk("line1_cnt", digit_cnt, 0);
      h_prev = 128'h0113df004fea93a20fb02c1fa5fda95d;

      // illegal character
      send_str("12");
      send_byte("G", EV_PERR, '0);
      send_byte("4", EV_NONE, '0);
      send_byte(CR, EV_NONE, '0);
      chk("illegal_hash_hold", hash, h_prev);
      chk("illegal_cnt", digit_cnt, 0);

      // 33 digits overflow
      send_str("ffffffffffffffffffffffffffffffff");
      send_byte("1", EV_PERR, '0);
      send_byte(CR, EV_NONE, '0);
      chk("overflow_hash_hold", hash, h_prev);
      chk("overflow_cnt", digit_cnt, 0);

      // short line
      send_str("ABC");
      send_byte(CR, EV_PERR, '0);
      chk("short_hash_hold", hash, h_prev);
      chk("short_cnt", digit_cnt, 0);

      // backspace handling: ignored in IDLE, returns to IDLE at zero
      send_byte(BS, EV_NONE, '0);
      send_byte("5", EV_NONE, '0);
      chk("bs_cnt1", digit_cnt, 1);
      send_byte(BS, EV_NONE, '0);
      chk("bs_cnt0", digit_cnt, 0);
      send_byte(CR, EV_NONE, '0);

      // 31 digits, BS, 2 new digits
      send_str("0123456789abcdef0123456789abcde");
      send_byte(BS, EV_NONE, '0);
      chk("bs_cnt30", digit_cnt, 30);
      send_str("F9");
      send_byte(CR, EV_HASH, 128'h0123456789abcdef0123456789abcdf9);
      chk("bs_hash", hash, 128'h0123456789abcdef0123456789abcdf9);
      h_prev = 128'h0123456789abcdef0123456789abcdf9;

      // rx_error overrides rx_valid in COLLECT, then FLUSH swallows the line
      send_byte("7", EV_NONE, '0);
      drive("8", 1'b1, 1'b1, EV_PERR, '0);
      chk("err_not_shifted", digit_cnt, 1);
      send_byte("9", EV_NONE, '0);
      drive(8'h00, 1'b0, 1'b1, EV_NONE, '0);
      send_byte("Z", EV_NONE, '0);
      send_byte(LF, EV_NONE, '0);
      chk("flush_cnt", digit_cnt, 0);
      chk("flush_hash_hold", hash, h_prev);

      // mixed-case line after recovery
      send_str("DEADBEEFdeadbeef0123456789ABCDEF");
      send_byte(CR, EV_HASH, 128'hdeadbeefdeadbeef0123456789abcdef);
      chk("mixed_hash", hash, 128'hdeadbeefdeadbeef0123456789abcdef);

      // single echo after the line quiets down; blank CR is ignored by the parser
      idle(50);
      tx_before = tx_cnt;
      send_byte(CR, EV_NONE, '0);
      idle(20);
      chk("echo_one", tx_cnt - tx_before, 1);
      chk("echo_byte", last_tx, CR);

      // transmitter stuck busy: only the first of three bytes is echoed
      idle(20);
      tx_before = tx_cnt;
      busy_force = 1'b1;
      send_str("123");
      idle(1000);
      chk("busy_no_tx", tx_cnt - tx_before, 0);
      busy_force = 1'b0;
      idle(30);
      chk("busy_one_tx", tx_cnt - tx_before, 1);
      chk("busy_first_byte", last_tx, "1");
      chk("busy_cnt3", digit_cnt, 3);

      // reset mid-line and mid-echo
      tx_before = tx_cnt;
      send_byte("4", EV_NONE, '0);
      rst = 1'b1;
      idle(3);
      chk("mid_rst_cnt", digit_cnt, 0);
      chk("mid_rst_hash", hash, '0);
      chk("mid_rst_tx_transmit", tx_transmit, 0);
      chk("mid_rst_tx_byte", tx_byte, 0);
      chk("mid_rst_pulses", {hash_valid, parse_error}, 2'b00);
      rst = 1'b0;
      idle(30);
      chk("mid_rst_echo_abandoned", tx_cnt - tx_before, 0);
      chk("mid_rst_cnt_after", digit_cnt, 0);

      chk("noecho_tx", tx0_cnt, 0);
      chk("sb_drained", exp_kind_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_hash_rx.md
UART_HASH_RX -- requirements
Module: uart_hash_rx

Interface
REQ-001 Parameter DIGITS, default 32: number of hex digits that make one complete hash (4*DIGITS result bits).
REQ-002 Parameter ECHO, default 1: 1 echoes accepted bytes back over the UART transmitter, 0 disables echo.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_byte is valid in that cycle (from uart received).
REQ-006 rx_byte  input  8  received character.
REQ-007 rx_error  input  1  one-cycle framing-error strobe (from uart recv_error).
REQ-008 tx_busy  input  1  transmitter busy (from uart is_transmitting).
REQ-009 tx_transmit  output  1  one-cycle request to send tx_byte.
REQ-010 tx_byte  output  8  echo character.
REQ-011 hash  output  4*DIGITS  last completed hash; first received digit lands in the MSB nibble.
REQ-012 hash_valid  output  1  one-cycle pulse when hash is updated.
REQ-013 parse_error  output  1  one-cycle pulse when a line is rejected.
REQ-014 digit_cnt  output  clog2(DIGITS+1)  digits collected on the current line.

Function
REQ-015 The state machine SHALL have three states: IDLE (count 0), COLLECT and FLUSH.
REQ-016 Character classes SHALL be: hex = '0'-'9', 'A'-'F', 'a'-'f'; EOL = 0x0D or 0x0A; BS = 0x08; any other byte is illegal.
REQ-017 A hex byte in IDLE/COLLECT with count<DIGITS SHALL shift sr <= {sr, nibble}, increment count and move to COLLECT.
REQ-018 A hex byte with count==DIGITS SHALL pulse parse_error and move to FLUSH.
REQ-019 An illegal byte in IDLE/COLLECT SHALL pulse parse_error and move to FLUSH.
REQ-020 BS in COLLECT SHALL shift sr right by 4, decrement count and return to IDLE when count reaches 0; BS in IDLE SHALL be ignored.
REQ-021 EOL in IDLE SHALL be ignored, so that CRLF pairs and blank lines are harmless.
REQ-022 EOL in COLLECT with count==DIGITS SHALL load hash <= sr, pulse hash_valid, clear count and go to IDLE.
REQ-023 EOL in COLLECT with count<DIGITS SHALL pulse parse_error, clear count and go to IDLE; hash SHALL be unchanged.
REQ-024 FLUSH SHALL discard every byte until EOL, then clear count and go to IDLE with no second parse_error.
REQ-025 rx_error SHALL override the same-cycle rx_valid.
REQ-026 rx_error in IDLE/COLLECT SHALL pulse parse_error and go to FLUSH; in FLUSH it SHALL keep FLUSH with no pulse.
REQ-027 hash_valid and parse_error SHALL be registered, asserted in the cycle after the triggering rx_valid/rx_error, and mutually exclusive.
REQ-028 hash SHALL hold its value between hash_valid pulses.
REQ-029 Echo (ECHO=1) uses a one-entry buffer:
- Every rx_valid byte SHALL be captured into the buffer when it is empty.
- The buffer is full from the cycle after capture.
- tx_transmit SHALL pulse for one cycle when the buffer is full, tx_busy is low and no request is outstanding.
- The buffer SHALL free after tx_busy is seen high and then low.
REQ-030 A byte arriving while the echo buffer is full SHALL still be parsed, but its echo SHALL be dropped.
REQ-031 With ECHO=0, tx_transmit SHALL stay 0.
REQ-032 tx_byte SHALL remain stable from the tx_transmit pulse until the buffer frees.

Reset
REQ-033 While rst is high, all of the following SHALL hold:
- state = IDLE, count = 0, sr = 0, hash = 0;
- hash_valid, parse_error, tx_transmit = 0;
- echo buffer empty, tx_byte = 0.
REQ-034 rst asserted mid-line or mid-echo SHALL abandon the line and the echo with no pulse on any output.

Verification
REQ-035 With DIGITS=32, send "0113df004fea93a20fb02c1fa5fda95d\r\n" -> one hash_valid pulse, hash=128'h0113df004fea93a20fb02c1fa5fda95d, and no parse_error for the trailing LF.
REQ-036 Send "12G4\r" -> one parse_error one cycle after 'G', no pulse on '\r', hash unchanged, digit_cnt=0 afterward.
REQ-037 Send 33 hex digits then '\r' -> parse_error on the 33rd digit, and hash is not updated.
REQ-038 Send 31 digits, BS, then 2 digits and '\r' -> hash_valid, and hash equals the 30 kept digits followed by the 2 new ones.
REQ-039 Pulse rx_error together with rx_valid in COLLECT -> parse_error, FLUSH state, and the byte is not shifted.
REQ-040 ECHO=1 with tx_busy held high for 1000 cycles while 3 bytes arrive -> exactly one tx_transmit (the first byte) and the other two echoes dropped; assert rst mid-line -> all outputs return to 0.
